// File: rtl/bp_be_pkg.sv
// bp_be_pkg: shared definitions for the back-end CLINT slice.
//   - MMIO address map (39-bit physical addresses, exact-match decode)
//   - bp_be_clint_state_e : response FSM states
//   - bp_be_mmio_req_s    : one MMIO request (write flag, address, data)
//   - bp_be_slot_addr()   : address of per-hart 8-byte register slot idx
package bp_be_pkg;

  localparam logic [38:0] bp_mmio_mtime_addr_gp          = 39'h6f_ffff_0000;
  localparam logic [38:0] bp_mmio_mtimecmp_base_addr_gp  = 39'h6f_ffff_0100;
  localparam logic [38:0] bp_mmio_msoftint_base_addr_gp  = 39'h6f_ffff_0200;

  typedef enum logic {
    e_idle = 1'b0,
    e_resp = 1'b1
  } bp_be_clint_state_e;

  typedef struct packed {
    logic        w;
    logic [38:0] addr;
    logic [63:0] data;
  } bp_be_mmio_req_s;

  // Per-hart registers are laid out as consecutive 64-bit words.
  function automatic logic [38:0] bp_be_slot_addr(input logic [38:0] base,
                                                  input int unsigned idx);
    return base + (39'(idx) << 3);
  endfunction

endpackage

// File: rtl/bp_be_clint_tick.sv
// bp_be_clint_tick: mtime prescaler.
//   Counts clk_i cycles and pulses tick_o for one cycle every tick_div_p
//   cycles (tick_o is high during the last count, so the consumer updates
//   on the edge where the counter wraps).
// Ports:
//   clk_i   - clock
//   reset_i - synchronous active-high reset, counter to 0
//   clear_i - restart the prescale period (counter to 0)
//   tick_o  - one-cycle increment strobe
module bp_be_clint_tick #(
  parameter int tick_div_p = 1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam logic [15:0] last_lp = 16'(tick_div_p - 1);

  logic [15:0] cnt_r;

  assign tick_o = (cnt_r == last_lp);

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      cnt_r <= '0;
    end else if (tick_o) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + 16'd1;
    end
  end

endmodule

// File: rtl/bp_be_clint.sv
// bp_be_clint: core-local interruptor (mtime / mtimecmp / msoftint).
//   Single-outstanding MMIO slave: a request is accepted in e_idle, the
//   response (read data, or 0 for writes) is held in e_resp until yumi.
//   Read data is captured at acceptance; writes land on the following edge.
//   Optional feature: define BP_BE_CLINT_MSOFTINT_EN to implement the
//   per-hart msoftint registers; otherwise those addresses are unmapped
//   and soft_irq_o is tied low.
// Ports:
//   clk_i, reset_i                     - clock, synchronous active-high reset
//   mmio_v_i/_w_i/_addr_i/_data_i      - request (valid, write, addr, data)
//   mmio_ready_o                       - request accepted when v & ready
//   mmio_resp_v_o/_data_o              - response valid / read data
//   mmio_resp_yumi_i                   - consumer takes the response
//   mtime_o                            - current mtime
//   timer_irq_o[i], soft_irq_o[i]      - per-hart machine interrupts
module bp_be_clint #(
  parameter int num_core_p = 1,
  parameter int tick_div_p = 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  mmio_v_i,
  input  logic                  mmio_w_i,
  input  logic [38:0]           mmio_addr_i,
  input  logic [63:0]           mmio_data_i,
  output logic                  mmio_ready_o,
  output logic                  mmio_resp_v_o,
  output logic [63:0]           mmio_resp_data_o,
  input  logic                  mmio_resp_yumi_i,
  output logic [63:0]           mtime_o,
  output logic [num_core_p-1:0] timer_irq_o,
  output logic [num_core_p-1:0] soft_irq_o
);

  import bp_be_pkg::*;

  bp_be_clint_state_e state_r, state_n;
  bp_be_mmio_req_s    req;
  logic               accept;

  assign req    = '{w: mmio_w_i, addr: mmio_addr_i, data: mmio_data_i};
  assign accept = mmio_v_i & mmio_ready_o;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= e_idle;
    end else begin
      state_r <= state_n;
    end
  end

  // NOTE: every output of this block is assigned a default first, so no
  // path through the case leaves a signal unassigned (no latch).
  always_comb begin
    state_n       = state_r;
    mmio_ready_o  = 1'b0;
    mmio_resp_v_o = 1'b0;
    case (state_r)
      e_idle: begin
        mmio_ready_o = 1'b1;
        if (mmio_v_i) state_n = e_resp;
      end
      e_resp: begin
        mmio_resp_v_o = 1'b1;
        if (mmio_resp_yumi_i) state_n = e_idle;
      end
    endcase
  end

  // ------------------------------------------------------------- decode
  // Exact 39-bit match; slots at or beyond num_core_p never hit.
  logic                  mtime_hit;
  logic [num_core_p-1:0] cmp_hit;

  assign mtime_hit = (req.addr == bp_mmio_mtime_addr_gp);

  always_comb begin
    cmp_hit = '0;
    for (int i = 0; i < num_core_p; i++) begin
      cmp_hit[i] = (req.addr == bp_be_slot_addr(bp_mmio_mtimecmp_base_addr_gp, i));
    end
  end

  // -------------------------------------------------------------- mtime
  logic [63:0] mtime_r;
  logic        tick;
  logic        mtime_wr;

  assign mtime_wr = accept & req.w & mtime_hit;

  bp_be_clint_tick #(
    .tick_div_p(tick_div_p)
  ) tick_u (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .clear_i(mtime_wr),
    .tick_o (tick)
  );

  // A software write wins over a coincident tick; the prescaler restarts.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mtime_r <= '0;
    end else if (mtime_wr) begin
      mtime_r <= req.data;
    end else if (tick) begin
      mtime_r <= mtime_r + 64'd1;
    end
  end

  assign mtime_o = mtime_r;

  // ----------------------------------------------------------- mtimecmp
  logic [63:0] mtimecmp_r [num_core_p];

  // NOTE: this small register array is reset element by element; it maps to
  // flops, not RAM, so resetting it is legal and required (all-ones = no irq).
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < num_core_p; i++) begin
        mtimecmp_r[i] <= '1;
      end
    end else begin
      for (int i = 0; i < num_core_p; i++) begin
        if (accept && req.w && cmp_hit[i]) begin
          mtimecmp_r[i] <= req.data;
        end
      end
    end
  end

  always_comb begin
    timer_irq_o = '0;
    for (int i = 0; i < num_core_p; i++) begin
      timer_irq_o[i] = (mtime_r >= mtimecmp_r[i]);
    end
  end

  // ----------------------------------------------------------- msoftint
`ifdef BP_BE_CLINT_MSOFTINT_EN
  logic [num_core_p-1:0] msip_hit;
  logic [num_core_p-1:0] msip_r;

  always_comb begin
    msip_hit = '0;
    for (int i = 0; i < num_core_p; i++) begin
      msip_hit[i] = (req.addr == bp_be_slot_addr(bp_mmio_msoftint_base_addr_gp, i));
    end
  end

  // Only bit 0 of the write data is architecturally meaningful.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      msip_r <= '0;
    end else begin
      for (int i = 0; i < num_core_p; i++) begin
        if (accept && req.w && msip_hit[i]) begin
          msip_r[i] <= req.data[0];
        end
      end
    end
  end

  assign soft_irq_o = msip_r;
`else
  assign soft_irq_o = '0;
`endif

  // ----------------------------------------------------------- read path
  logic [63:0] rdata;

  always_comb begin
    rdata = '0;
    if (mtime_hit) rdata = mtime_r;
    for (int i = 0; i < num_core_p; i++) begin
      if (cmp_hit[i]) rdata = mtimecmp_r[i];
`ifdef BP_BE_CLINT_MSOFTINT_EN
      if (msip_hit[i]) rdata = {63'b0, msip_r[i]};
`endif
    end
  end

  // Captured at acceptance so the value predates any same-cycle update,
  // and held unchanged for the whole e_resp phase.
  logic [63:0] resp_data_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      resp_data_r <= '0;
    end else if (accept) begin
      resp_data_r <= req.w ? 64'd0 : rdata;
    end
  end

  assign mmio_resp_data_o = resp_data_r;

endmodule

// File: tb/tb_bp_be_clint.sv
// tb_bp_be_clint: directed self-checking bench for bp_be_clint
// (num_core_p=2, tick_div_p=4). Inputs change on the falling edge and
// outputs are sampled there too, away from the active rising edge.
module tb_bp_be_clint;

  localparam logic [38:0] a_mtime = 39'h6f_ffff_0000;
  localparam logic [38:0] a_cmp0  = 39'h6f_ffff_0100;
  localparam logic [38:0] a_cmp1  = 39'h6f_ffff_0108;
  localparam logic [38:0] a_cmp2  = 39'h6f_ffff_0110;
  localparam logic [38:0] a_msip0 = 39'h6f_ffff_0200;
  localparam logic [38:0] a_msip1 = 39'h6f_ffff_0208;
  localparam logic [63:0] ones    = 64'hFFFF_FFFF_FFFF_FFFF;

`ifdef BP_BE_CLINT_MSOFTINT_EN
  localparam logic [1:0]  exp_soft  = 2'b10;
  localparam logic [63:0] exp_msip1 = 64'd1;
`else
  localparam logic [1:0]  exp_soft  = 2'b00;
  localparam logic [63:0] exp_msip1 = 64'd0;
`endif

  logic        clk = 1'b0;
  logic        reset_i;
  logic        mmio_v_i, mmio_w_i, mmio_resp_yumi_i;
  logic [38:0] mmio_addr_i;
  logic [63:0] mmio_data_i;
  logic        mmio_ready_o, mmio_resp_v_o;
  logic [63:0] mmio_resp_data_o, mtime_o;
  logic [1:0]  timer_irq_o, soft_irq_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bp_be_clint #(
    .num_core_p(2),
    .tick_div_p(4)
  ) dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .mmio_v_i        (mmio_v_i),
    .mmio_w_i        (mmio_w_i),
    .mmio_addr_i     (mmio_addr_i),
    .mmio_data_i     (mmio_data_i),
    .mmio_ready_o    (mmio_ready_o),
    .mmio_resp_v_o   (mmio_resp_v_o),
    .mmio_resp_data_o(mmio_resp_data_o),
    .mmio_resp_yumi_i(mmio_resp_yumi_i),
    .mtime_o         (mtime_o),
    .timer_irq_o     (timer_irq_o),
    .soft_irq_o      (soft_irq_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; returns on the falling edge after acceptance.
  task automatic accept_req(input logic w, input logic [38:0] addr, input logic [63:0] data);
    int n = 0;
    mmio_v_i = 1'b1; mmio_w_i = w; mmio_addr_i = addr; mmio_data_i = data;
    while (!mmio_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("ready_timeout", {63'b0, mmio_ready_o}, 64'd1);
    @(negedge clk);
    mmio_v_i = 1'b0; mmio_w_i = 1'b0;
  endtask

  task automatic finish_resp(input string tag, input logic [63:0] exp);
    check({tag, "_v"}, {63'b0, mmio_resp_v_o}, 64'd1);
    check(tag, mmio_resp_data_o, exp);
    mmio_resp_yumi_i = 1'b1;
    @(negedge clk);
    mmio_resp_yumi_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b1; mmio_v_i = 1'b0; mmio_w_i = 1'b0; mmio_resp_yumi_i = 1'b0;
    mmio_addr_i = '0; mmio_data_i = '0;
    repeat (3) @(negedge clk);
    check("rst_resp_v", {63'b0, mmio_resp_v_o}, 64'd0);
    check("rst_timer",  {62'b0, timer_irq_o}, 64'd0);
    check("rst_soft",   {62'b0, soft_irq_o}, 64'd0);
    check("rst_mtime",  mtime_o, 64'd0);
    reset_i = 1'b0;
    check("rst_ready",  {63'b0, mmio_ready_o}, 64'd1);

    // mtimecmp reset value and unmapped slots
    accept_req(1'b0, a_cmp0, '0);
    finish_resp("cmp0_rst", ones);
    check("timer_after_rst", {62'b0, timer_irq_o}, 64'd0);
    accept_req(1'b0, a_cmp2, '0);
    finish_resp("unmapped_rd", 64'd0);
    accept_req(1'b1, a_cmp2, 64'd0);
    finish_resp("unmapped_wr", 64'd0);
    accept_req(1'b0, a_cmp1, '0);
    finish_resp("cmp1_rst", ones);
    check("timer_unmapped_wr", {62'b0, timer_irq_o}, 64'd0);

    // prescaled increment: write 10, +1 every 4 cycles
    accept_req(1'b1, a_mtime, 64'd10);
    finish_resp("mtime_wr_resp", 64'd0);
    check("mtime_10_a", mtime_o, 64'd10);
    repeat (2) @(negedge clk);
    check("mtime_10_b", mtime_o, 64'd10);
    @(negedge clk);
    check("mtime_11", mtime_o, 64'd11);
    repeat (4) @(negedge clk);
    check("mtime_12", mtime_o, 64'd12);
    accept_req(1'b0, a_mtime, '0);
    finish_resp("mtime_rd_12", 64'd12);

    // mtime write restarts the prescaler, and wins over a coincident tick
    accept_req(1'b1, a_mtime, 64'd200);
    finish_resp("mtime_wr200", 64'd0);
    @(negedge clk);
    accept_req(1'b1, a_mtime, 64'd300);
    check("mtime_300_a", mtime_o, 64'd300);
    finish_resp("mtime_wr300", 64'd0);
    check("presc_clear_a", mtime_o, 64'd300);
    repeat (2) @(negedge clk);
    check("presc_clear_b", mtime_o, 64'd300);
    @(negedge clk);
    check("presc_clear_c", mtime_o, 64'd301);
    repeat (3) @(negedge clk);
    accept_req(1'b1, a_mtime, 64'd400);
    check("wr_wins_tick", mtime_o, 64'd400);
    finish_resp("mtime_wr400", 64'd0);
    repeat (2) @(negedge clk);
    check("mtime_400", mtime_o, 64'd400);
    @(negedge clk);
    check("mtime_401", mtime_o, 64'd401);

    // timer interrupt on hart 1
    accept_req(1'b1, a_mtime, 64'd100);
    finish_resp("mtime_wr100", 64'd0);
    accept_req(1'b1, a_cmp1, 64'd105);
    finish_resp("cmp1_wr", 64'd0);
    check("timer_pre", {62'b0, timer_irq_o}, 64'd0);
    repeat (16) @(negedge clk);
    check("timer_104", {62'b0, timer_irq_o}, 64'd0);
    @(negedge clk);
    check("timer_105", {62'b0, timer_irq_o}, 64'b10);
    check("mtime_105", mtime_o, 64'd105);
    accept_req(1'b1, a_cmp1, ones);
    check("timer_cleared", {62'b0, timer_irq_o}, 64'd0);
    finish_resp("cmp1_wr_ones", 64'd0);

    // 64-bit wrap
    accept_req(1'b1, a_mtime, ones);
    check("mtime_max", mtime_o, ones);
    check("timer_at_max", {62'b0, timer_irq_o}, 64'b11);
    finish_resp("mtime_wr_max", 64'd0);
    repeat (2) @(negedge clk);
    check("mtime_max_hold", mtime_o, ones);
    @(negedge clk);
    check("mtime_wrap", mtime_o, 64'd0);
    check("timer_after_wrap", {62'b0, timer_irq_o}, 64'd0);

    // backpressure: response held while yumi is low, next request waits
    accept_req(1'b0, a_cmp0, '0);
    mmio_v_i = 1'b1; mmio_w_i = 1'b0; mmio_addr_i = a_cmp2;
    for (int k = 0; k < 4; k++) begin
      check("bp_ready", {63'b0, mmio_ready_o}, 64'd0);
      check("bp_resp_v", {63'b0, mmio_resp_v_o}, 64'd1);
      check("bp_data", mmio_resp_data_o, ones);
      if (k < 3) @(negedge clk);
    end
    mmio_resp_yumi_i = 1'b1;
    @(negedge clk);
    mmio_resp_yumi_i = 1'b0;
    check("bp_ready_after", {63'b0, mmio_ready_o}, 64'd1);
    check("bp_resp_v_after", {63'b0, mmio_resp_v_o}, 64'd0);
    @(negedge clk);
    mmio_v_i = 1'b0;
    finish_resp("bp_second", 64'd0);

    // software interrupt
    accept_req(1'b1, a_msip1, 64'd3);
    check("soft_irq", {62'b0, soft_irq_o}, {62'b0, exp_soft});
    finish_resp("msip_wr", 64'd0);
    accept_req(1'b0, a_msip1, '0);
    finish_resp("msip1_rd", exp_msip1);
    accept_req(1'b0, a_msip0, '0);
    finish_resp("msip0_rd", 64'd0);

    // reset during e_resp drops the response
    accept_req(1'b0, a_cmp1, '0);
    check("inflight_v", {63'b0, mmio_resp_v_o}, 64'd1);
    reset_i = 1'b1;
    @(negedge clk);
    check("inflight_dropped", {63'b0, mmio_resp_v_o}, 64'd0);
    @(negedge clk);
    reset_i = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_resp_v", {63'b0, mmio_resp_v_o}, 64'd0);
    check("post_rst_soft", {62'b0, soft_irq_o}, 64'd0);
    check("post_rst_timer", {62'b0, timer_irq_o}, 64'd0);
    check("post_rst_mtime", mtime_o, 64'd0);
    accept_req(1'b0, a_msip1, '0);
    finish_resp("post_rst_msip1", 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
